// File: rtl/sad_pkg.sv
// sad_pkg: shared definitions for the SAD window array.
//   clog2         - ceiling log2 for elaboration-time widths (clog2(1) = 0)
//   sad_width_ok  - 1 when an accumulator of sad_w bits can hold the
//                   largest possible window SAD without overflowing
//   sad_state_e   - template load / run state of the matcher
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } sad_state_e;

    function automatic int clog2(input longint unsigned value);
        int              bits;
        longint unsigned reach;
        bits  = 0;
        reach = 1;
        while (reach < value) begin
            reach = reach << 1;
            bits++;
        end
        return bits;
    endfunction

    // Worst case is every pixel of the T_H x T_W window at maximum distance.
    function automatic bit sad_width_ok(input int sad_w, input int t_h,
                                        input int t_w, input int pix_w);
        longint unsigned max_sad;
        max_sad = longint'(t_h) * longint'(t_w) * ((longint'(1) << pix_w) - 1);
        return sad_w >= clog2(max_sad + 1);
    endfunction

endpackage

// File: rtl/sad_col_pe.sv
// sad_col_pe: absolute-difference sum of one image column slice against one
// template column. Purely combinational.
//   pix_i  T_H pixels of the image column, row k at [k*PIX_W +: PIX_W]
//   tpl_i  T_H pixels of the template column, same packing
//   sad_o  sum over k of |pix[k] - tpl[k]|, zero-extended to SAD_W
module sad_col_pe
    import sad_pkg::*;
#(
    parameter int T_H   = 8,
    parameter int PIX_W = 8,
    parameter int SAD_W = 16
) (
    input  logic [T_H*PIX_W-1:0] pix_i,
    input  logic [T_H*PIX_W-1:0] tpl_i,
    output logic [SAD_W-1:0]     sad_o
);

    always_comb begin
        sad_o = '0;
        for (int k = 0; k < T_H; k++) begin
            if (pix_i[k*PIX_W +: PIX_W] >= tpl_i[k*PIX_W +: PIX_W]) begin
                sad_o = sad_o + SAD_W'(pix_i[k*PIX_W +: PIX_W] - tpl_i[k*PIX_W +: PIX_W]);
            end else begin
                sad_o = sad_o + SAD_W'(tpl_i[k*PIX_W +: PIX_W] - pix_i[k*PIX_W +: PIX_W]);
            end
        end
    end

endmodule

// File: rtl/sad_window_array.sv
// sad_window_array: T_H x T_W template matcher over a stream of image columns.
// One column of N_ROWS pixels is accepted per cycle; for each of the N_OUT
// vertical window positions the SAD over the last T_W columns is built up in a
// systolic chain of partial sums, and one registered result per column reports
// threshold flags and the minimum SAD with its row.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   tpl_load_i        pulse: (re)enter template load, clears pipeline state
//   tpl_valid_i       template column strobe, tpl_col_i row k at [k*PIX_W +: PIX_W]
//   in_valid_i        image column valid; in_ready_o high only while running
//   in_sol_i          with in_valid_i: column is column 0 of a new line
//   in_col_i          image column, row r at [r*PIX_W +: PIX_W]
//   thresh_i          match threshold, sampled with each accepted column
//   out_valid_o       one-cycle result pulse, one cycle after the column
//   out_col_o         column index of the window's rightmost column
//   sad_flag_o        bit r set when SAD of the window at row r <= threshold
//   best_sad_o        minimum SAD of the column, best_row_o its lowest row
//   match_any_o       OR of sad_flag_o
//
// Handshake: a column transfers on a clock edge where in_valid_i && in_ready_o;
// in_ready_o does not depend on in_valid_i. Result fields hold their values
// while out_valid_o is low.
module sad_window_array
    import sad_pkg::*;
#(
    parameter  int N_ROWS = 64,
    parameter  int T_H    = 8,
    parameter  int T_W    = 8,
    parameter  int PIX_W  = 8,
    parameter  int SAD_W  = 16,
    parameter  int COL_W  = 12,
    localparam int N_OUT  = N_ROWS - T_H + 1,
    localparam int ROW_W  = (N_OUT > 1) ? clog2(N_OUT) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    tpl_load_i,
    input  logic                    tpl_valid_i,
    input  logic [T_H*PIX_W-1:0]    tpl_col_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    in_sol_i,
    input  logic [N_ROWS*PIX_W-1:0] in_col_i,
    input  logic [SAD_W-1:0]        thresh_i,
    output logic                    out_valid_o,
    output logic [COL_W-1:0]        out_col_o,
    output logic [N_OUT-1:0]        sad_flag_o,
    output logic [SAD_W-1:0]        best_sad_o,
    output logic [ROW_W-1:0]        best_row_o,
    output logic                    match_any_o
);

    localparam int TIDX_W = (T_W > 1) ? clog2(T_W) : 1;
    localparam int N_STG  = T_W - 1;

    if (T_W < 2) begin : g_bad_tw
        $error("sad_window_array: T_W must be at least 2");
    end
    if (!sad_width_ok(SAD_W, T_H, T_W, PIX_W)) begin : g_bad_sad_w
        $error("sad_window_array: SAD_W too small for the worst-case window SAD");
    end

    sad_state_e              state_q, state_d;
    logic [TIDX_W-1:0]       tidx_q;
    logic [T_H*PIX_W-1:0]    tpl_q   [T_W];
    logic [SAD_W-1:0]        stage_q [N_STG][N_OUT];
    logic [COL_W-1:0]        col_cnt_q;

    logic                    out_valid_q;
    logic [COL_W-1:0]        out_col_q;
    logic [N_OUT-1:0]        sad_flag_q;
    logic [SAD_W-1:0]        best_sad_q;
    logic [ROW_W-1:0]        best_row_q;
    logic                    match_any_q;

    logic [SAD_W-1:0]        colsad  [T_W][N_OUT];
    logic [SAD_W-1:0]        full    [N_OUT];
    logic [N_OUT-1:0]        flag_c;
    logic [SAD_W-1:0]        best_sad_c;
    logic [ROW_W-1:0]        best_row_c;

    logic                    last_tpl;
    logic                    tpl_wr;
    logic                    accept;
    logic [COL_W-1:0]        col_idx;
    logic                    col_emit;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign last_tpl   = (tidx_q == TIDX_W'(T_W - 1));
    // tpl_load_i takes priority over a template column in the same cycle.
    assign tpl_wr     = (state_q == LOAD) && tpl_valid_i && !tpl_load_i;
    assign in_ready_o = (state_q == RUN);
    // A column offered together with tpl_load_i is dropped by the reload.
    assign accept     = in_ready_o && in_valid_i && !tpl_load_i;
    assign col_idx    = in_sol_i ? '0 : col_cnt_q;
    assign col_emit   = (col_idx >= COL_W'(T_W - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (tpl_load_i) state_d = LOAD;
            LOAD: begin
                if (tpl_load_i) begin
                    state_d = LOAD;
                end else if (tpl_valid_i && last_tpl) begin
                    state_d = RUN;
                end
            end
            RUN:  if (tpl_load_i) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Template registers survive tpl_load_i; only a write replaces a column.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tidx_q <= '0;
            for (int j = 0; j < T_W; j++) begin
                tpl_q[j] <= '0;
            end
        end else if (tpl_load_i) begin
            tidx_q <= '0;
        end else if (tpl_wr) begin
            tpl_q[tidx_q] <= tpl_col_i;
            tidx_q        <= last_tpl ? '0 : tidx_q + TIDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Column SAD array: template column j against every window row r
    // ------------------------------------------------------------------
    for (genvar j = 0; j < T_W; j++) begin : g_tcol
        for (genvar r = 0; r < N_OUT; r++) begin : g_row
            sad_col_pe #(
                .T_H   (T_H),
                .PIX_W (PIX_W),
                .SAD_W (SAD_W)
            ) u_pe (
                .pix_i (in_col_i[r*PIX_W +: T_H*PIX_W]),
                .tpl_i (tpl_q[j]),
                .sad_o (colsad[j][r])
            );
        end
    end

    // ------------------------------------------------------------------
    // Window totals and best search. stage_q[j] holds the partial window
    // whose newest column met template column j; the current column closes
    // the window against template column T_W-1. A start-of-line column sees
    // an empty chain so nothing from the previous line leaks in.
    // ------------------------------------------------------------------
    always_comb begin
        best_sad_c = '0;
        best_row_c = '0;
        flag_c     = '0;
        for (int r = 0; r < N_OUT; r++) begin
            full[r]   = (in_sol_i ? '0 : stage_q[N_STG-1][r]) + colsad[T_W-1][r];
            flag_c[r] = (full[r] <= thresh_i);
        end
        best_sad_c = full[0];
        // Strict less-than keeps the lowest row on ties.
        for (int r = 1; r < N_OUT; r++) begin
            if (full[r] < best_sad_c) begin
                best_sad_c = full[r];
                best_row_c = ROW_W'(r);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage chain, column counter and registered result
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || tpl_load_i) begin
            col_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            sad_flag_q  <= '0;
            best_sad_q  <= '0;
            best_row_q  <= '0;
            match_any_q <= 1'b0;
            for (int j = 0; j < N_STG; j++) begin
                for (int r = 0; r < N_OUT; r++) begin
                    stage_q[j][r] <= '0;
                end
            end
        end else if (accept) begin
            col_cnt_q <= in_sol_i ? COL_W'(1) : col_cnt_q + COL_W'(1);
            for (int r = 0; r < N_OUT; r++) begin
                stage_q[0][r] <= colsad[0][r];
                for (int j = 1; j < N_STG; j++) begin
                    stage_q[j][r] <= (in_sol_i ? '0 : stage_q[j-1][r]) + colsad[j][r];
                end
            end
            out_valid_q <= col_emit;
            if (col_emit) begin
                out_col_q   <= col_idx;
                sad_flag_q  <= flag_c;
                best_sad_q  <= best_sad_c;
                best_row_q  <= best_row_c;
                match_any_q <= |flag_c;
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_col_o   = out_col_q;
    assign sad_flag_o  = sad_flag_q;
    assign best_sad_o  = best_sad_q;
    assign best_row_o  = best_row_q;
    assign match_any_o = match_any_q;

endmodule

// File: doc/sad_window_array.md
Name: sad_window_array

Overview:
- Parametrised 2-D template matcher for the SAD processor.
- Accepts one image column of N_ROWS pixels per cycle and holds a T_H x T_W template in registers.
- For every vertical window position, computes the full SAD over the T_W most recent columns using a systolic horizontal accumulation chain.
- Per column, emits threshold match flags plus the best (minimum) SAD and its row; sits between the column streamer and the match-reporting logic.

Parameters:
- N_ROWS, 64: pixels per input column.
- T_H, 8: template height.
- T_W, 8: template width (>=2).
- PIX_W, 8: bits per pixel (1 = binary image).
- SAD_W, 16: accumulator width; elaboration error if < clog2(T_H*T_W*(2^PIX_W-1)+1).
- COL_W, 12: column counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tpl_load  in  1  pulse: enter LOAD, restart template column index
- tpl_valid  in  1  template column strobe
- tpl_col  in  T_H*PIX_W  template column, row k at bits [k*PIX_W +: PIX_W]
- in_valid  in  1  image column valid
- in_ready  out  1  high only in RUN
- in_sol  in  1  with in_valid: column is col 0 of a new line
- in_col  in  N_ROWS*PIX_W  image column, row r at bits [r*PIX_W +: PIX_W]
- thresh  in  SAD_W  match threshold, sampled per accepted column
- out_valid  out  1  result pulse
- out_col  out  COL_W  column index of the window's rightmost column
- sad_flag  out  N_OUT  bit r = 1 iff SAD(window at row r) <= thresh; N_OUT = N_ROWS-T_H+1
- best_sad  out  SAD_W  minimum SAD of the column
- best_row  out  clog2(N_OUT)  row of best_sad; ties -> lowest row
- match_any  out  1  OR of sad_flag

Behaviour:
- FSM IDLE -> LOAD on tpl_load. In LOAD, each tpl_valid writes template column tidx, then tidx++. LOAD -> RUN when tidx = T_W-1 is written.
- tpl_load in RUN or LOAD: return to LOAD, tidx=0, clear all stage registers and col_cnt. Template contents are retained until overwritten.
- Accept an input column when in_valid && in_ready. Otherwise hold all state.
- colsad(j,r) = sum over k=0..T_H-1 of |in_col[r+k] - tpl[k][j]|, unsigned, zero-extended to SAD_W.
- On accept: stage[0][r] <= colsad(0,r); stage[j][r] <= stage[j-1][r] + colsad(j,r) for j=1..T_W-2. full[r] = stage[T_W-2][r] + colsad(T_W-1,r) is combinational. No saturation is needed (width check).
- col_cnt: in_sol accept -> the column is col 0, stage chain is treated as cleared (stage[j] writes use zero for j-1), and col_cnt <= 1. Otherwise col_cnt++, wrapping at 2^COL_W.
- Output registered, 1-cycle latency. out_valid=1 the cycle after an accepted column whose index c >= T_W-1. out_col=c; sad_flag, best_sad, best_row, match_any are derived from full[].
- No output for c < T_W-1, i.e. a partial window after in_sol.
- Outputs hold their values when out_valid=0.
- Best search: linear min over r, strict-less compare, so ties give the lowest r.
- Reset state:
  - FSM IDLE, in_ready=0, out_valid=0.
  - sad_flag=0, best_sad=0, best_row=0, match_any=0, out_col=0.
  - Stages, template and col_cnt = 0.
  - Reset mid-frame discards everything; a template reload is required.
- in_valid in IDLE/LOAD: ignored, in_ready=0.
- tpl_valid in IDLE/RUN: ignored.
- tpl_load and tpl_valid in the same cycle: tpl_load wins and the data is dropped.

Decomposition:
- Package sad_pkg: clog2 function, SAD width check function, FSM state enum (IDLE, LOAD, RUN).
- Sub-module sad_col_pe: combinational T_H-pixel absolute-difference adder tree for one (j,r). N_OUT*T_W instances.
- The top level holds the FSM, template registers, stage chain, counter, and the min/flag output stage.

Test Plan:
- Reset, then load T_W columns, then stream. Check in_ready rises only after the 8th tpl_valid; out_valid stays 0 for cols 0..6; first out_valid is 1 cycle after col 7 with out_col=7.
- Template all 0x10; image all 0x10 except a 0x00 region at rows 20..27, cols 30..37; thresh=0. Check that while the window overlaps the region, sad_flag[20] stays 0 (e.g. col 37: best_sad=0 from rows 0..12 or 28..56, best_row=0). Check col 7: sad_flag all 1, best_row=0.
- Image = template embedded at rows 5..12, cols 40..47, noise elsewhere; thresh=0. Check at out_col=47: sad_flag = only bit 5, best_sad=0, best_row=5, match_any=1.
- All image pixels 0xFF, template all 0x00. Check best_sad = 64*255 = 16320 with no overflow; thresh=16319 gives match_any=0, thresh=16320 gives match_any=1.
- in_sol asserted mid-line at col 20. Check no out_valid for the next 7 accepted columns; the next result carries out_col=7 and excludes pre-in_sol pixels.
- Assert rst during RUN, and separately tpl_load during RUN. Check all outputs reach reset values and in_ready=0; check stages clear and no stale result appears after reload.
